uart_mem_loader: RTL
====================

// Module: uart_mem_loader
// PURPOSE
//   Upstream feeder for the word memory: receives a program/data image over a UART RX line
//   (8N1), packs bytes little-endian into 32-bit words and writes them to consecutive
//   word-aligned byte addresses 0,4,8,... through the memory write port.
//   Sits between the board RX pin and the memory's mem_addr/i_mem_data/mem_rw inputs; after
//   the image is loaded the system muxes the memory back to its normal reader.
// PARAMETERS
//   CLK_HZ     27_000_000  system clock frequency in Hz
//   BAUD       115_200     UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, >= 4)
//   NUM_WORDS  256         words to load before asserting done (>= 1)
// PORTS
//   clk         in   1   system clock; all logic on rising edge
//   reset       in   1   asynchronous, active-high reset
//   uart_rx     in   1   serial input, idle high, asynchronous to clk
//   mem_addr    out  32  byte address of current write, always multiple of 4
//   mem_wdata   out  32  word to write (drives memory i_mem_data)
//   mem_rw      out  1   1 = read/idle, 0 = write; low for exactly one clk per word
//   busy        out  1   high while a UART frame is being received
//   done        out  1   sticky: NUM_WORDS words written
//   frame_err   out  1   sticky: at least one frame had stop bit = 0
//   word_count  out  16  number of words written so far
// BEHAVIOUR
//   Reset: mem_addr=0, mem_wdata=0, mem_rw=1, busy=0, done=0, frame_err=0, word_count=0,
//     byte index=0, FSM=IDLE, RX synchroniser flops preset to 1. Reset mid-frame or with a
//     partial word discards all partial data; nothing is written.
//   Input: uart_rx passes a 2-flop synchroniser; all decisions use the synchronised value.
//   FSM (bit-period counter reloads on every state change):
//     IDLE : sync rx == 0 -> START, busy=1. Ignored (stays IDLE) while done=1.
//     START: wait CLKS_PER_BIT/2 clks; sample: 0 -> DATA; 1 -> IDLE (glitch, no byte, busy=0).
//     DATA : wait CLKS_PER_BIT per bit, sample 8 bits LSB first into shift reg -> STOP.
//     STOP : wait CLKS_PER_BIT, sample: 1 -> byte valid; 0 -> byte discarded, frame_err=1.
//            Either way -> IDLE, busy=0 in the same cycle the stop bit is sampled.
//   Packing: valid byte k (k = byte index 0..3) placed at mem_wdata[8k+7:8k]; index += 1.
//     On index 3 the word completes: next clk mem_rw=0 for one cycle with mem_addr and
//     mem_wdata stable; the following clk mem_rw=1, mem_addr += 4, word_count += 1,
//     index = 0. Write latency: 1 clk after the 4th stop bit is sampled.
//   mem_wdata holds its last value between writes; only mem_rw qualifies a write.
//   Termination: when word_count reaches NUM_WORDS, done=1 in the same cycle; further
//     start bits ignored, mem_rw stays 1, mem_addr stays at 4*NUM_WORDS.
//   Address arithmetic: 32-bit, wraps modulo 2^32 (unreachable for legal NUM_WORDS).
//   A new start bit may arrive while the write strobe is pending; the strobe is independent
//     of the RX FSM and a following byte is never lost.
// TESTING  (sim: CLK_HZ=16, BAUD=1 -> CLKS_PER_BIT=16; NUM_WORDS=2)
//   Frames 0x78,0x56,0x34,0x12 -> single mem_rw=0 pulse, mem_addr=0, mem_wdata=0x12345678;
//     afterwards mem_addr=4, word_count=1, done=0.
//   Second word 0xEF,0xBE,0xAD,0xDE -> write 0xDEADBEEF @ addr 4; done=1, word_count=2;
//     a further frame 0xAA produces no write and busy stays 0.
//   rx low for 4 clks then high -> FSM returns to IDLE, no byte, byte index unchanged.
//   Frame 0x55 with stop bit 0 -> frame_err=1, byte discarded; next 4 good bytes form the word.
//   reset asserted after 2 of 4 bytes -> all outputs at reset values, next 4 bytes write addr 0.
//   Back-to-back frames (no idle gap) -> every byte captured, one mem_rw pulse per 4 bytes.

Source files
------------

// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Receives an image over an 8N1 UART line, packs bytes little-endian into
//   32-bit words and writes them to byte addresses 0,4,8,... through a simple
//   memory write port. Stops after NUM_WORDS words and raises done.
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   uart_rx    serial input, idle high, asynchronous to clk
//   mem_addr   byte address of the current write (multiple of 4)
//   mem_wdata  word to write; holds its value between writes
//   mem_rw     1 = idle/read, 0 = write (one clk per word)
//   busy       high while a UART frame is being received
//   done       sticky, NUM_WORDS words written
//   frame_err  sticky, a frame had a low stop bit
//   word_count number of words written so far
module uart_mem_loader #(
  parameter int unsigned CLK_HZ    = 27_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned NUM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  output logic        busy,
  output logic        done,
  output logic        frame_err,
  output logic [15:0] word_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [15:0]      LAST_WORD = 16'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [1:0]       byte_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_idx   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rw     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;

      // Write strobe release runs independently of the receiver so a frame
      // starting during the strobe is not disturbed.
      if (!mem_rw) begin
        mem_rw     <= 1'b1;
        mem_addr   <= mem_addr + 32'd4;
        word_count <= word_count + 16'd1;
        if (word_count == LAST_WORD) begin
          done <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!done && !rx_sync) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_sync) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_sync) begin
              mem_wdata[{byte_idx, 3'b000} +: 8] <= shift;
              // 2-bit index wraps to 0 here rather than on strobe release;
              // no byte can complete in between, so the result is identical.
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                mem_rw <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
